// File: rtl/ecc_pkg.sv
// Shared definitions for the pipelined ECC fault detector.
//   ecc_parity_width : SECDED parity width needed for a given payload width
//   ecc_data_pos     : Hamming codeword position (1-based) of payload bit idx
//   ecc_cnt_sat      : saturation value of a w-bit error counter
//   st_state_e       : comparator self-test FSM states
package ecc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_WAIT  = 2'd2
    } st_state_e;

    // Hamming check bits r satisfy 2^r >= d + r + 1; one extra overall parity bit.
    function automatic int ecc_parity_width(input int data_width);
        int r = 0;
        for (int k = 2; k < 31; k++) begin
            if (r == 0 && (1 << k) >= data_width + k + 1) r = k;
        end
        return r + 1;
    endfunction

    // Payload bits occupy the non-power-of-two codeword positions in order.
    function automatic int ecc_data_pos(input int idx);
        int cnt = 0;
        int pos = 0;
        for (int p = 3; p < idx + 40; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx && pos == 0) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic logic [31:0] ecc_cnt_sat(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/ecc_cal.sv
// SECDED decode core (combinational).
//   bypass    : forces no error report and an all-zero correction mask
//   data_in   : stored payload
//   parity_in : stored check bits [PARITY_WIDTH-2:0] plus overall parity (MSB)
//   sbit      : single-bit error (overall parity wrong)
//   dbit      : double-bit error (overall parity right, syndrome non-zero)
//   mask      : payload bit to flip for correction (one-hot or zero)
module ecc_cal
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH   = 195,
    parameter int PARITY_WIDTH = ecc_parity_width(DATA_WIDTH)
) (
    input  logic                    bypass,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PARITY_WIDTH-1:0] parity_in,
    output logic                    sbit,
    output logic                    dbit,
    output logic [DATA_WIDTH-1:0]   mask
);

    localparam int SYN_W = PARITY_WIDTH - 1;

    logic [SYN_W-1:0] pos_tab [DATA_WIDTH];
    logic [SYN_W-1:0] syndrome;
    logic             overall_err;

    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_pos
        assign pos_tab[j] = SYN_W'(ecc_data_pos(j));
    end

    // Each check bit covers the positions with its index bit set, so the
    // syndrome is the stored check bits XOR the positions of all set payload bits.
    always_comb begin
        syndrome = parity_in[SYN_W-1:0];
        for (int j = 0; j < DATA_WIDTH; j++) begin
            if (data_in[j]) syndrome = syndrome ^ pos_tab[j];
        end
    end

    assign overall_err = ^{data_in, parity_in};

    // A single error in a check bit or the overall bit sets sbit with an empty mask.
    always_comb begin
        sbit = 1'b0;
        dbit = 1'b0;
        mask = '0;
        if (!bypass) begin
            sbit = overall_err;
            dbit = ~overall_err & (syndrome != '0);
            for (int j = 0; j < DATA_WIDTH; j++) begin
                mask[j] = overall_err & (syndrome == pos_tab[j]);
            end
        end
    end

endmodule

// File: rtl/ecc_fault_detc_pipe.sv
// Pipelined lockstep ECC fault detector.
// Two redundant SECDED cores decode each accepted beat; their {sbit,dbit,mask}
// are compared and the corrected (or, on mismatch, raw) word is registered.
//   clk, rst (sync, active-high)
//   ecc_fault_detc_en : enables the lockstep comparison
//   bypass            : both cores report no error and apply no correction
//   in_valid/in_ready, data_in, parity_in     : input beat
//   out_valid/out_ready, data_out, sbit_err, dbit_err, ecc_fault : output beat
//   clr_stat, fault_sticky, sbit_cnt, dbit_cnt, fault_cnt       : statistics
//   selftest_req/busy/done/pass : comparator self-test
module ecc_fault_detc_pipe
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH   = 195,
    parameter int PARITY_WIDTH = 9,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ecc_fault_detc_en,
    input  logic                    bypass,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PARITY_WIDTH-1:0] parity_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    sbit_err,
    output logic                    dbit_err,
    output logic                    ecc_fault,
    output logic                    fault_sticky,
    input  logic                    clr_stat,
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    output logic [CNT_WIDTH-1:0]    fault_cnt,
    input  logic                    selftest_req,
    output logic                    selftest_busy,
    output logic                    selftest_done,
    output logic                    selftest_pass
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(ecc_cnt_sat(CNT_WIDTH));

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_WIDTH'(1);
    endfunction

    logic                  c0_sbit, c0_dbit, c1_sbit, c1_dbit;
    logic [DATA_WIDTH-1:0] c0_mask, c1_mask, c1_mask_cmp;
    logic                  inject, compare_ok;
    logic                  accept, out_hs;
    logic                  fault_p0;
    logic [DATA_WIDTH-1:0] data_p0;

    logic                  vld_p1, sbit_p1, dbit_p1, fault_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    st_state_e             st_q, st_d;
    logic                  done_q, done_d, pass_q, pass_d;

    logic [CNT_WIDTH-1:0]  sbit_cnt_q, dbit_cnt_q, fault_cnt_q;
    logic                  sticky_q;

    ecc_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u0_ecc_cal (
        .bypass    (bypass),
        .data_in   (data_in),
        .parity_in (parity_in),
        .sbit      (c0_sbit),
        .dbit      (c0_dbit),
        .mask      (c0_mask)
    );

    ecc_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u1_ecc_cal (
        .bypass    (bypass),
        .data_in   (data_in),
        .parity_in (parity_in),
        .sbit      (c1_sbit),
        .dbit      (c1_dbit),
        .mask      (c1_mask)
    );

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign out_hs   = vld_p1 & out_ready;

    // ---- stage p0: lockstep compare (self-test corrupts core1 while ARMED) ----
    assign inject      = (st_q == ST_ARMED);
    assign c1_mask_cmp = c1_mask ^ {{(DATA_WIDTH-1){1'b0}}, inject};
    assign compare_ok  = ({c0_sbit, c0_dbit, c0_mask} == {c1_sbit, c1_dbit, c1_mask_cmp});
    assign fault_p0    = ~compare_ok & ecc_fault_detc_en;
    // A disputed correction is not trusted: pass the stored word through untouched.
    assign data_p0     = fault_p0 ? data_in : (data_in ^ c0_mask);

    // ---- stage p1: output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            sbit_p1  <= 1'b0;
            dbit_p1  <= 1'b0;
            fault_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1   <= 1'b1;
            data_p1  <= data_p0;
            sbit_p1  <= c0_sbit;
            dbit_p1  <= c0_dbit;
            fault_p1 <= fault_p0;
        end else if (out_hs) begin
            vld_p1   <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign data_out  = data_p1;
    assign sbit_err  = sbit_p1;
    assign dbit_err  = dbit_p1;
    assign ecc_fault = fault_p1;

    // Statistics count delivered beats; clr_stat beats a simultaneous increment.
    always_ff @(posedge clk) begin
        if (rst || clr_stat) begin
            sbit_cnt_q  <= '0;
            dbit_cnt_q  <= '0;
            fault_cnt_q <= '0;
            sticky_q    <= 1'b0;
        end else if (out_hs) begin
            if (sbit_p1)  sbit_cnt_q  <= sat_inc(sbit_cnt_q);
            if (dbit_p1)  dbit_cnt_q  <= sat_inc(dbit_cnt_q);
            if (fault_p1) fault_cnt_q <= sat_inc(fault_cnt_q);
            if (fault_p1) sticky_q    <= 1'b1;
        end
    end

    assign sbit_cnt     = sbit_cnt_q;
    assign dbit_cnt     = dbit_cnt_q;
    assign fault_cnt    = fault_cnt_q;
    assign fault_sticky = sticky_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    // WAIT is entered on the injected accept, so the next output handshake
    // is always the injected beat itself.
    always_comb begin
        st_d   = st_q;
        done_d = 1'b0;
        pass_d = pass_q;
        case (st_q)
            ST_IDLE: begin
                if (selftest_req) begin
                    st_d   = ST_ARMED;
                    pass_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (accept) st_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (out_hs) begin
                    st_d   = ST_IDLE;
                    done_d = 1'b1;
                    pass_d = fault_p1;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    assign selftest_busy = (st_q != ST_IDLE);
    assign selftest_done = done_q;
    assign selftest_pass = pass_q;

endmodule

// File: tb/tb_ecc_fault_detc_pipe.sv
// Self-checking bench for ecc_fault_detc_pipe (DATA_WIDTH=195, CNT_WIDTH=4).
module tb_ecc_fault_detc_pipe;

    localparam int DW = 195;
    localparam int PW = 9;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ecc_fault_detc_en;
    logic          bypass;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_in;
    logic [PW-1:0] parity_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data_out;
    logic          sbit_err, dbit_err, ecc_fault, fault_sticky;
    logic          clr_stat;
    logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
    logic          selftest_req, selftest_busy, selftest_done, selftest_pass;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ecc_fault_detc_pipe #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .ecc_fault_detc_en (ecc_fault_detc_en),
        .bypass            (bypass),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .data_in           (data_in),
        .parity_in         (parity_in),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .data_out          (data_out),
        .sbit_err          (sbit_err),
        .dbit_err          (dbit_err),
        .ecc_fault         (ecc_fault),
        .fault_sticky      (fault_sticky),
        .clr_stat          (clr_stat),
        .sbit_cnt          (sbit_cnt),
        .dbit_cnt          (dbit_cnt),
        .fault_cnt         (fault_cnt),
        .selftest_req      (selftest_req),
        .selftest_busy     (selftest_busy),
        .selftest_done     (selftest_done),
        .selftest_pass     (selftest_pass)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            flip_a;   // payload bit to corrupt, -1 for none
        int            flip_b;
        int            pflip;    // parity bit to corrupt, -1 for none
        logic          byp;
        logic          en;
        logic          exp_sbit;
        logic          exp_dbit;
        logic          exp_raw;  // 1: expect the corrupted word back, 0: the clean word
    } vec_t;

    vec_t vt [10];

    // Reference encoder: lay the payload into a Hamming codeword, then derive
    // each check bit from the positions it covers.
    function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
        logic [255:0]  cw;
        logic [PW-1:0] p;
        int            j;
        cw = '0;
        j  = 0;
        for (int pos = 1; pos < 256; pos++) begin
            if ((pos & (pos - 1)) != 0 && j < DW) begin
                cw[pos] = d[j];
                j++;
            end
        end
        p = '0;
        for (int i = 0; i < PW - 1; i++) begin
            for (int q = 1; q < 256; q++) begin
                if (q[i]) p[i] = p[i] ^ cw[q];
            end
        end
        p[PW-1] = (^d) ^ (^p[PW-2:0]);
        return p;
    endfunction

    function automatic logic [DW-1:0] mk(input int k);
        logic [223:0] t;
        t = {7{32'(k + 1) * 32'h9E37_79B1}};
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] pat5a();
        logic [199:0] t;
        t = {25{8'h5A}};
        return t[DW-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input int fa, input int fb,
                              input int pf, output logic [DW-1:0] sent);
        logic [DW-1:0] dd;
        logic [PW-1:0] p;
        p  = enc(d);
        dd = d;
        if (fa >= 0) dd[fa] = ~dd[fa];
        if (fb >= 0) dd[fb] = ~dd[fb];
        if (pf >= 0) p[pf] = ~p[pf];
        data_in   = dd;
        parity_in = p;
        in_valid  = 1'b1;
        sent      = dd;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chkc(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    logic [DW-1:0] sent, sent_x, sent_y;

    initial begin
        vt[0] = '{data: mk(200), flip_a: -1,  flip_b: -1,  pflip: -1, byp: 1'b0, en: 1'b1, exp_sbit: 1'b0, exp_dbit: 1'b0, exp_raw: 1'b0};
        vt[1] = '{data: mk(201), flip_a: 17,  flip_b: -1,  pflip: -1, byp: 1'b0, en: 1'b1, exp_sbit: 1'b1, exp_dbit: 1'b0, exp_raw: 1'b0};
        vt[2] = '{data: mk(202), flip_a: 0,   flip_b: 194, pflip: -1, byp: 1'b0, en: 1'b1, exp_sbit: 1'b0, exp_dbit: 1'b1, exp_raw: 1'b1};
        vt[3] = '{data: mk(203), flip_a: -1,  flip_b: -1,  pflip: 3,  byp: 1'b0, en: 1'b1, exp_sbit: 1'b1, exp_dbit: 1'b0, exp_raw: 1'b0};
        vt[4] = '{data: mk(204), flip_a: -1,  flip_b: -1,  pflip: 8,  byp: 1'b0, en: 1'b1, exp_sbit: 1'b1, exp_dbit: 1'b0, exp_raw: 1'b0};
        vt[5] = '{data: mk(205), flip_a: 5,   flip_b: -1,  pflip: -1, byp: 1'b1, en: 1'b1, exp_sbit: 1'b0, exp_dbit: 1'b0, exp_raw: 1'b1};
        vt[6] = '{data: mk(206), flip_a: 5,   flip_b: 6,   pflip: -1, byp: 1'b1, en: 1'b1, exp_sbit: 1'b0, exp_dbit: 1'b0, exp_raw: 1'b1};
        vt[7] = '{data: mk(207), flip_a: 194, flip_b: -1,  pflip: -1, byp: 1'b0, en: 1'b1, exp_sbit: 1'b1, exp_dbit: 1'b0, exp_raw: 1'b0};
        vt[8] = '{data: mk(208), flip_a: 100, flip_b: -1,  pflip: -1, byp: 1'b0, en: 1'b0, exp_sbit: 1'b1, exp_dbit: 1'b0, exp_raw: 1'b0};
        vt[9] = '{data: mk(209), flip_a: 100, flip_b: 101, pflip: -1, byp: 1'b0, en: 1'b1, exp_sbit: 1'b0, exp_dbit: 1'b1, exp_raw: 1'b1};

        rst = 1'b1; ecc_fault_detc_en = 1'b1; bypass = 1'b0;
        in_valid = 1'b0; data_in = '0; parity_in = '0; out_ready = 1'b1;
        clr_stat = 1'b0; selftest_req = 1'b0;
        step();
        step();

        // Reset state
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        chkd("rst_data_out", data_out, '0);
        chk1("rst_sbit", sbit_err, 1'b0);
        chk1("rst_dbit", dbit_err, 1'b0);
        chk1("rst_fault", ecc_fault, 1'b0);
        chk1("rst_sticky", fault_sticky, 1'b0);
        chkc("rst_sbit_cnt", sbit_cnt, '0);
        chkc("rst_fault_cnt", fault_cnt, '0);
        chk1("rst_busy", selftest_busy, 1'b0);
        chk1("rst_done", selftest_done, 1'b0);
        chk1("rst_pass", selftest_pass, 1'b0);
        rst = 1'b0;
        step();

        // Clean stream at full throughput
        for (int k = 0; k < 100; k++) begin
            drive_beat(mk(k), -1, -1, -1, sent);
            step();
            chk1("stream_valid", out_valid, 1'b1);
            chkd("stream_data", data_out, sent);
            chk1("stream_sbit", sbit_err, 1'b0);
            chk1("stream_dbit", dbit_err, 1'b0);
            chk1("stream_fault", ecc_fault, 1'b0);
        end
        in_valid = 1'b0;
        step();
        chk1("stream_drain", out_valid, 1'b0);
        chkc("stream_sbit_cnt", sbit_cnt, 4'd0);
        chkc("stream_dbit_cnt", dbit_cnt, 4'd0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            bypass            = vt[i].byp;
            ecc_fault_detc_en = vt[i].en;
            drive_beat(vt[i].data, vt[i].flip_a, vt[i].flip_b, vt[i].pflip, sent);
            step();
            chk1($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk1($sformatf("vec%0d_sbit", i), sbit_err, vt[i].exp_sbit);
            chk1($sformatf("vec%0d_dbit", i), dbit_err, vt[i].exp_dbit);
            chk1($sformatf("vec%0d_fault", i), ecc_fault, 1'b0);
            chkd($sformatf("vec%0d_data", i), data_out, vt[i].exp_raw ? sent : vt[i].data);
        end
        in_valid = 1'b0; bypass = 1'b0; ecc_fault_detc_en = 1'b1;
        step();
        chkc("table_sbit_cnt", sbit_cnt, 4'd5);
        chkc("table_dbit_cnt", dbit_cnt, 4'd2);
        chkc("table_fault_cnt", fault_cnt, 4'd0);
        chk1("table_sticky", fault_sticky, 1'b0);
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        chkc("clr_sbit_cnt", sbit_cnt, 4'd0);
        chkc("clr_dbit_cnt", dbit_cnt, 4'd0);

        // Backpressure: hold for 4 cycles, then release
        drive_beat(mk(400), -1, -1, -1, sent_x);
        step();
        out_ready = 1'b0;
        drive_beat(mk(401), -1, -1, -1, sent_y);
        for (int c = 0; c < 4; c++) begin
            step();
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_valid", out_valid, 1'b1);
            chkd("bp_hold_data", data_out, sent_x);
        end
        out_ready = 1'b1;
        step();
        chk1("bp_rel_valid", out_valid, 1'b1);
        chkd("bp_rel_data", data_out, sent_y);
        in_valid = 1'b0;
        step();
        chk1("bp_drain", out_valid, 1'b0);

        // Self-test with comparison enabled; the beat also carries a single-bit error
        selftest_req = 1'b1;
        step();
        selftest_req = 1'b0;
        chk1("st1_busy", selftest_busy, 1'b1);
        drive_beat(pat5a(), 17, -1, -1, sent);
        step();
        in_valid = 1'b0;
        chk1("st1_valid", out_valid, 1'b1);
        chk1("st1_fault", ecc_fault, 1'b1);
        chkd("st1_raw_data", data_out, sent);
        chk1("st1_sbit", sbit_err, 1'b1);
        chk1("st1_done_early", selftest_done, 1'b0);
        step();
        chk1("st1_done", selftest_done, 1'b1);
        chk1("st1_pass", selftest_pass, 1'b1);
        chk1("st1_busy_clr", selftest_busy, 1'b0);
        chkc("st1_fault_cnt", fault_cnt, 4'd1);
        chk1("st1_sticky", fault_sticky, 1'b1);
        step();
        chk1("st1_done_pulse", selftest_done, 1'b0);
        chk1("st1_pass_held", selftest_pass, 1'b1);

        // Self-test with comparison disabled
        selftest_req = 1'b1;
        step();
        selftest_req = 1'b0;
        ecc_fault_detc_en = 1'b0;
        drive_beat(pat5a(), -1, -1, -1, sent);
        step();
        in_valid = 1'b0;
        chk1("st2_fault", ecc_fault, 1'b0);
        chkd("st2_data", data_out, sent);
        step();
        chk1("st2_done", selftest_done, 1'b1);
        chk1("st2_pass", selftest_pass, 1'b0);
        chkc("st2_fault_cnt", fault_cnt, 4'd1);
        ecc_fault_detc_en = 1'b1;

        // Saturation of a 4-bit counter
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive_beat(mk(300 + k), 17, -1, -1, sent);
            step();
        end
        in_valid = 1'b0;
        step();
        chkc("sat_sbit_cnt", sbit_cnt, 4'd15);
        chk1("sat_sticky_clr", fault_sticky, 1'b0);
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        drive_beat(mk(350), 17, -1, -1, sent);
        step();
        in_valid = 1'b0;
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        chkc("clr_wins", sbit_cnt, 4'd0);

        // Reset while the injected beat waits at the output
        selftest_req = 1'b1;
        step();
        selftest_req = 1'b0;
        drive_beat(mk(500), -1, -1, -1, sent);
        step();
        in_valid = 1'b0;
        chk1("mid_valid_pre", out_valid, 1'b1);
        chk1("mid_busy_pre", selftest_busy, 1'b1);
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        chk1("mid_valid", out_valid, 1'b0);
        chk1("mid_busy", selftest_busy, 1'b0);
        chk1("mid_done", selftest_done, 1'b0);
        step();
        chk1("mid_done_after", selftest_done, 1'b0);
        chk1("mid_valid_after", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
